// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D scan front-end.
//   - a2d_state_e : conversion sequencer states
//   - CH_W/RES_W  : channel and result widths
//   - build_cmd() : SPI command word for a channel
// Optional build macro: A2D_AVG_EN (4-read averaging, see a2d_scan_intf).
package a2d_pkg;

    localparam int unsigned CH_W  = 3;
    localparam int unsigned RES_W = 12;
    localparam int unsigned CMD_W = 16;

    localparam logic [1:0]  CMD_PAD_HI = 2'b00;
    localparam logic [10:0] CMD_PAD_LO = 11'h000;

    typedef enum logic [2:0] {
        StIdle,
        StTxCh,
        StGap,
        StTxRd,
        StCapt
    } a2d_state_e;

    function automatic logic [CMD_W-1:0] build_cmd(input logic [CH_W-1:0] ch);
        return {CMD_PAD_HI, ch, CMD_PAD_LO};
    endfunction

endpackage

// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched: picks the next conversion source for the sequencer.
//   Holds the single pending-request slot, the scan gap counter and the
//   round-robin scan pointer. Priority: pending > strt_cnv > expired scan.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   strt_cnv_i, chnnl_i : user request and its channel
//   scan_en_i           : enables the autonomous scan
//   fsm_idle_i          : sequencer is in IDLE and will accept start_req_o
//   capt_i              : sequencer is in CAPT (conversion finishing)
//   start_req_o         : a conversion should start now (if idle)
//   start_ch_o          : channel for that conversion
// Optional build macro: none (A2D_AVG_EN does not affect this block).
module a2d_scan_sched
    import a2d_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SCAN_GAP = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strt_cnv_i,
    input  logic [CH_W-1:0] chnnl_i,
    input  logic            scan_en_i,
    input  logic            fsm_idle_i,
    input  logic            capt_i,
    output logic            start_req_o,
    output logic [CH_W-1:0] start_ch_o
);

    localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);

    logic             pend_vld_q, pend_vld_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [CH_W-1:0]  scan_ptr_q, scan_ptr_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    // Set while the conversion in flight was launched by the scan.
    logic             scan_act_q, scan_act_d;

    logic scan_due;
    logic take_scan;

    assign scan_due = scan_en_i && (gap_cnt_q == GAP_W'(SCAN_GAP));

    always_comb begin
        start_req_o = 1'b0;
        start_ch_o  = scan_ptr_q;
        take_scan   = 1'b0;
        if (pend_vld_q) begin
            start_req_o = 1'b1;
            start_ch_o  = pend_ch_q;
        end else if (strt_cnv_i) begin
            start_req_o = 1'b1;
            start_ch_o  = chnnl_i;
        end else if (scan_due) begin
            start_req_o = 1'b1;
            take_scan   = fsm_idle_i;
        end
    end

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_ch_d  = pend_ch_q;
        if (fsm_idle_i && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end
        // A request that cannot be served directly this cycle (busy, or
        // the slot is being drained) lands in the slot, overwriting it.
        if (strt_cnv_i && (!fsm_idle_i || pend_vld_q)) begin
            pend_vld_d = 1'b1;
            pend_ch_d  = chnnl_i;
        end
    end

    always_comb begin
        gap_cnt_d  = gap_cnt_q;
        scan_ptr_d = scan_ptr_q;
        scan_act_d = scan_act_q;
        if (!scan_en_i) begin
            gap_cnt_d = '0;
        end else if (capt_i && scan_act_q) begin
            gap_cnt_d = '0;
        end else if (fsm_idle_i && !scan_due) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
        // Expired count holds while a user request pre-empts the scan.
        if (capt_i && scan_act_q) begin
            scan_act_d = 1'b0;
            scan_ptr_d = (scan_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : scan_ptr_q + 1'b1;
        end else if (take_scan) begin
            scan_act_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            scan_ptr_q <= '0;
            gap_cnt_q  <= '0;
            scan_act_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_ch_q  <= pend_ch_d;
            scan_ptr_q <= scan_ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            scan_act_q <= scan_act_d;
        end
    end

endmodule

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: sequences A2D conversions over a 16-bit SPI master.
//   Each conversion: channel-select transaction, TXN_GAP idle clocks, then
//   the read transaction returning the 12-bit result.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   strt_cnv, chnnl : single-conversion request and channel
//   scan_en         : enables round-robin scan over 0..NUM_CH-1
//   done, rd_data   : SPI master completion and read data
//   wrt, cmd        : SPI master start pulse and command word
//   busy            : conversion in progress (from the first wrt)
//   cnv_cmplt       : one-cycle pulse when res/res_chnl update
//   res, res_chnl   : last result and its channel
// Optional build macro: A2D_AVG_EN -- four read transactions per conversion,
//   summed in a 14-bit accumulator; res is the sum divided by four.
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned SCAN_GAP = 16,
    parameter int unsigned TXN_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_cnv,
    input  logic [CH_W-1:0]   chnnl,
    input  logic              scan_en,
    input  logic              done,
    input  logic [CMD_W-1:0]  rd_data,
    output logic              wrt,
    output logic [CMD_W-1:0]  cmd,
    output logic              busy,
    output logic              cnv_cmplt,
    output logic [RES_W-1:0]  res,
    output logic [CH_W-1:0]   res_chnl
);

    localparam int unsigned TG_W = (TXN_GAP < 1) ? 1 : $clog2(TXN_GAP + 1);

    a2d_state_e         state_q, state_d;
    logic [TG_W-1:0]    gap_q, gap_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [CH_W-1:0]    res_chnl_q, res_chnl_d;
    logic               cnv_cmplt_q, cnv_cmplt_d;
`ifdef A2D_AVG_EN
    localparam int unsigned ACC_W = RES_W + 2;
    logic [1:0]         rd_cnt_q, rd_cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
`endif

    logic               start_req;
    logic [CH_W-1:0]    start_ch;
    logic               fsm_idle;
    logic               fsm_capt;
    logic               unused_rd_hi;

    assign unused_rd_hi = ^rd_data[CMD_W-1:RES_W];

    assign fsm_idle = (state_q == StIdle);
    assign fsm_capt = (state_q == StCapt);

    a2d_scan_sched #(
        .NUM_CH   (NUM_CH),
        .SCAN_GAP (SCAN_GAP)
    ) u_sched (
        .clk         (clk),
        .rst_n       (rst_n),
        .strt_cnv_i  (strt_cnv),
        .chnnl_i     (chnnl),
        .scan_en_i   (scan_en),
        .fsm_idle_i  (fsm_idle),
        .capt_i      (fsm_capt),
        .start_req_o (start_req),
        .start_ch_o  (start_ch)
    );

    // A start in IDLE is taken in the request cycle, so busy covers it too.
    assign busy      = !fsm_idle || start_req;
    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;
    assign res_chnl  = res_chnl_q;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        cmd_d       = cmd_q;
        ch_d        = ch_q;
        res_d       = res_q;
        res_chnl_d  = res_chnl_q;
        cnv_cmplt_d = 1'b0;
        wrt         = 1'b0;
        cmd         = cmd_q;
`ifdef A2D_AVG_EN
        rd_cnt_d    = rd_cnt_q;
        acc_d       = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    wrt     = 1'b1;
                    cmd_d   = build_cmd(start_ch);
                    // Only the launch cycle bypasses the register.
                    cmd     = cmd_d;
                    ch_d    = start_ch;
                    state_d = StTxCh;
`ifdef A2D_AVG_EN
                    rd_cnt_d = '0;
                    acc_d    = '0;
`endif
                end
            end
            StTxCh: begin
                if (done) begin
                    gap_d   = TG_W'(TXN_GAP);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    wrt     = 1'b1;
                    state_d = StTxRd;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            StTxRd: begin
                if (done) begin
`ifdef A2D_AVG_EN
                    acc_d    = acc_q + {2'b00, rd_data[RES_W-1:0]};
                    rd_cnt_d = rd_cnt_q + 2'd1;
                    if (rd_cnt_q == 2'd3) begin
                        state_d = StCapt;
                    end else begin
                        gap_d   = TG_W'(TXN_GAP);
                        state_d = StGap;
                    end
`else
                    state_d = StCapt;
`endif
                end
            end
            StCapt: begin
`ifdef A2D_AVG_EN
                res_d = acc_q[ACC_W-1:2];
`else
                res_d = rd_data[RES_W-1:0];
`endif
                res_chnl_d  = ch_q;
                cnv_cmplt_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            cmd_q       <= '0;
            ch_q        <= '0;
            res_q       <= '0;
            res_chnl_q  <= '0;
            cnv_cmplt_q <= 1'b0;
`ifdef A2D_AVG_EN
            rd_cnt_q    <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            cmd_q       <= cmd_d;
            ch_q        <= ch_d;
            res_q       <= res_d;
            res_chnl_q  <= res_chnl_d;
            cnv_cmplt_q <= cnv_cmplt_d;
`ifdef A2D_AVG_EN
            rd_cnt_q    <= rd_cnt_d;
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb_a2d_scan_intf: directed bench for a2d_scan_intf with a simple SPI
// responder (done four clocks after each wrt). Honours A2D_AVG_EN.
module tb_a2d_scan_intf;
    import a2d_pkg::*;

    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned SCAN_GAP = 16;
    localparam int unsigned TXN_GAP  = 2;
`ifdef A2D_AVG_EN
    localparam int NRD = 4;
`else
    localparam int NRD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        scan_en;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        busy;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  res_chnl;

    a2d_scan_intf #(
        .NUM_CH   (NUM_CH),
        .SCAN_GAP (SCAN_GAP),
        .TXN_GAP  (TXN_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .scan_en   (scan_en),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .res_chnl  (res_chnl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event log, sampled on the falling edge.
    int          wrt_cyc_q[$];
    logic [15:0] wrt_cmd_q[$];
    int          done_cyc_q[$];
    int          cmp_cyc_q[$];
    logic [11:0] res_q[$];
    logic [2:0]  rch_q[$];
    logic [15:0] last_cmd = '0;
    int          cmd_glitch = 0;

    always @(negedge clk) begin
        if (wrt) begin
            wrt_cyc_q.push_back(cyc);
            wrt_cmd_q.push_back(cmd);
            last_cmd <= cmd;
        end else if (busy && (cmd !== last_cmd)) begin
            cmd_glitch <= cmd_glitch + 1;
        end
        if (done) done_cyc_q.push_back(cyc);
        if (cnv_cmplt) begin
            cmp_cyc_q.push_back(cyc);
            res_q.push_back(res);
            rch_q.push_back(res_chnl);
        end
    end

    task automatic clear_log();
        wrt_cyc_q.delete();
        wrt_cmd_q.delete();
        done_cyc_q.delete();
        cmp_cyc_q.delete();
        res_q.delete();
        rch_q.delete();
    endtask

    // SPI responder: 0 = FABC reads, 1 = F100+ch, 2 = F100+read index.
    int spi_en    = 1;
    int data_mode = 0;
    int txn_k     = 0;

    function automatic logic [15:0] resp(input int k, input logic [2:0] ch);
        if (k == 0) return 16'hDEAD;
        case (data_mode)
            0:       return 16'hFABC;
            1:       return 16'hF100 + {13'd0, ch};
            default: return 16'hF100 + 16'(k - 1);
        endcase
    endfunction

    initial begin
        int          k;
        logic [2:0]  rch;
        done    = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (wrt && spi_en != 0) begin
                k     = txn_k;
                txn_k = (txn_k == NRD) ? 0 : txn_k + 1;
                rch   = cmd[13:11];
                repeat (4) @(posedge clk);
                #1;
                done    = 1'b1;
                rd_data = resp(k, rch);
                @(posedge clk);
                #1;
                done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds strt_cnv for one cycle.
    task automatic pulse_strt(input logic [2:0] ch);
        strt_cnv = 1'b1;
        chnnl    = ch;
        step();
        strt_cnv = 1'b0;
        chnnl    = 3'd7;
    endtask

    task automatic wait_cmplt(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && cmp_cyc_q.size() < n; i++) @(negedge clk);
        check_eq(tag, cmp_cyc_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e_cyc, d0, wc, lastd, len, nw;
        rst_n    = 1'b0;
        strt_cnv = 1'b0;
        chnnl    = '0;
        scan_en  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wrt", wrt, 0);
        check_eq("rst_cmplt", cnv_cmplt, 0);
        check_eq("rst_res", res, 0);
        check_eq("rst_res_chnl", res_chnl, 0);
        check_eq("rst_cmd", cmd, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single conversion on channel 3
        clear_log();
        data_mode = 0;
        strt_cnv  = 1'b1;
        chnnl     = 3'd3;
        @(negedge clk);
        check_eq("t1_wrt_same_cycle", wrt, 1);
        check_eq("t1_busy_same_cycle", busy, 1);
        check_eq("t1_cmd_comb", cmd, 16'h1800);
        step();
        strt_cnv = 1'b0;
        chnnl    = 3'd7;
        wait_cmplt("t1_cmplt_seen", 1, 200);
        repeat (4) step();
        check_eq("t1_wrt_count", wrt_cyc_q.size(), 1 + NRD);
        check_eq("t1_cmd_first", wrt_cmd_q[0], 16'h1800);
        check_eq("t1_cmd_second", wrt_cmd_q[1], 16'h1800);
        check_eq("t1_gap", wrt_cyc_q[1] - done_cyc_q[0], TXN_GAP + 1);
        check_eq("t1_res", res, 12'hABC);
        check_eq("t1_res_chnl", res_chnl, 3);
        check_eq("t1_latency", cmp_cyc_q[0] - done_cyc_q[done_cyc_q.size() - 1], 2);
        check_eq("t1_cmplt_once", cmp_cyc_q.size(), 1);
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_cmd_stable", cmd_glitch, 0);

        // Round-robin scan over channels 0..2
        clear_log();
        data_mode = 1;
        scan_en   = 1'b1;
        e_cyc     = cyc;
        wait_cmplt("t2_cmplt_seen", 4, 600);
        scan_en = 1'b0;
        check_eq("t2_first_start", wrt_cyc_q[0] - e_cyc, SCAN_GAP);
        check_eq("t2_ch0", rch_q[0], 0);
        check_eq("t2_ch1", rch_q[1], 1);
        check_eq("t2_ch2", rch_q[2], 2);
        check_eq("t2_ch3", rch_q[3], 0);
        check_eq("t2_res0", res_q[0], 12'h100);
        check_eq("t2_res1", res_q[1], 12'h101);
        check_eq("t2_res2", res_q[2], 12'h102);
        check_eq("t2_res3", res_q[3], 12'h100);
        for (int i = 0; i < 3; i++) begin
            len = (cmp_cyc_q[i] - 1) - wrt_cyc_q[i * (1 + NRD)] + 1;
            check_eq("t2_spacing", wrt_cyc_q[(i + 1) * (1 + NRD)] - wrt_cyc_q[i * (1 + NRD)],
                     len + SCAN_GAP);
        end
        repeat (4) step();

        // Pending slot: scan on ch1, requests 5 then 6 while busy
        clear_log();
        scan_en = 1'b1;
        fork
            begin
                int i;
                for (i = 0; i < 100 && !busy; i++) @(negedge clk);
                check_eq("t3_scan_started", busy, 1);
                repeat (2) @(posedge clk);
                #1;
                pulse_strt(3'd5);
                repeat (2) @(posedge clk);
                #1;
                pulse_strt(3'd6);
            end
            wait_cmplt("t3_cmplt_seen", 3, 600);
        join
        scan_en = 1'b0;
        check_eq("t3_first_ch", rch_q[0], 1);
        check_eq("t3_second_ch", rch_q[1], 6);
        check_eq("t3_second_res", res_q[1], 12'h106);
        check_eq("t3_third_ch", rch_q[2], 2);
        check_eq("t3_pend_cmd", wrt_cmd_q[1 + NRD], 16'h3000);
        check_eq("t3_pend_start", wrt_cyc_q[1 + NRD], cmp_cyc_q[0]);
        check_eq("t3_scan_cmd", wrt_cmd_q[2 * (1 + NRD)], 16'h1000);
        repeat (4) step();

        // Reset asserted while in the inter-transaction gap
        clear_log();
        data_mode = 0;
        pulse_strt(3'd4);
        for (int i = 0; i < 50 && done_cyc_q.size() < 1; i++) @(negedge clk);
        check_eq("t4_first_done", done_cyc_q.size(), 1);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_wrt", wrt, 0);
        check_eq("t4_rst_cmplt", cnv_cmplt, 0);
        check_eq("t4_rst_res", res, 0);
        repeat (3) step();
        rst_n = 1'b1;
        txn_k = 0;
        step();
        clear_log();
        pulse_strt(3'd0);
        wait_cmplt("t4_cmplt_seen", 1, 200);
        repeat (4) step();
        check_eq("t4_wrt_count", wrt_cyc_q.size(), 1 + NRD);
        check_eq("t4_cmd0", wrt_cmd_q[0], 16'h0000);
        check_eq("t4_cmd1", wrt_cmd_q[1], 16'h0000);
        check_eq("t4_res", res, 12'hABC);
        check_eq("t4_res_chnl", res_chnl, 0);

        // Spurious done in IDLE and a double done during the gap
        spi_en = 0;
        clear_log();
        done = 1'b1;
        step();
        done = 1'b0;
        repeat (8) step();
        check_eq("t5_idle_wrt", wrt_cyc_q.size(), 0);
        check_eq("t5_idle_cmplt", cmp_cyc_q.size(), 0);
        check_eq("t5_idle_busy", busy, 0);
        pulse_strt(3'd2);
        repeat (3) step();
        d0   = cyc;
        done = 1'b1;
        step();
        step();
        step();
        done = 1'b0;
        wc   = cyc;
        lastd = 0;
        for (int r = 0; r < NRD; r++) begin
            repeat (4) step();
            done    = 1'b1;
            rd_data = 16'hF123;
            lastd   = cyc;
            step();
            done = 1'b0;
            repeat (2) step();
        end
        repeat (3) step();
        nw = wrt_cyc_q.size();
        check_eq("t5_wrt_count", nw, 1 + NRD);
        check_eq("t5_wrt_after_gap", wrt_cyc_q[1] - d0, TXN_GAP + 1);
        check_eq("t5_wrt_cycle", wrt_cyc_q[1], wc);
        check_eq("t5_cmplt_count", cmp_cyc_q.size(), 1);
        check_eq("t5_latency", cmp_cyc_q[0] - lastd, 2);
        check_eq("t5_res", res_q[0], 12'h123);
        check_eq("t5_res_chnl", rch_q[0], 2);
        spi_en = 1;
        repeat (2) step();

`ifdef A2D_AVG_EN
        // Averaging: reads 100..103 average to 101
        clear_log();
        data_mode = 2;
        txn_k     = 0;
        pulse_strt(3'd1);
        wait_cmplt("t6_cmplt_seen", 1, 300);
        repeat (4) step();
        check_eq("t6_wrt_count", wrt_cyc_q.size(), 5);
        check_eq("t6_res", res, 12'h101);
        check_eq("t6_res_chnl", res_chnl, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
